// File: rtl/lab4_ssd_scan_pkg.sv
// Shared constants for the lab4_ssd_scan seven-segment scan driver.
// Segment encoding is {a,b,c,d,e,f,g,dp}, active-low.
package lab4_ssd_scan_pkg;

   typedef enum logic {
      GUARD = 1'b0,
      SHOW  = 1'b1
   } state_e;

   localparam logic [7:0] SS_0     = 8'b0000_0011;
   localparam logic [7:0] SS_1     = 8'b1001_1111;
   localparam logic [7:0] SS_2     = 8'b0010_0101;
   localparam logic [7:0] SS_3     = 8'b0000_1101;
   localparam logic [7:0] SS_4     = 8'b1001_1001;
   localparam logic [7:0] SS_5     = 8'b0100_1001;
   localparam logic [7:0] SS_6     = 8'b0100_0001;
   localparam logic [7:0] SS_7     = 8'b0001_1111;
   localparam logic [7:0] SS_8     = 8'b0000_0001;
   localparam logic [7:0] SS_9     = 8'b0000_1001;
   localparam logic [7:0] SS_F     = 8'b0111_0001;
   localparam logic [7:0] SS_BLANK = 8'hFF;
   localparam logic [3:0] DIG_OFF  = 4'b1111;

   // One-cold enable for the selected digit.
   function automatic logic [3:0] digit_enable(input logic [1:0] idx);
      digit_enable = ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/lab4_ssd_scan_if.sv
// Digit-pattern inputs and multiplexed display outputs of lab4_ssd_scan.
interface lab4_ssd_scan_if;
   logic [7:0] dig0;
   logic [7:0] dig1;
   logic [7:0] dig2;
   logic [7:0] dig3;
   logic [3:0] blank_mask;
   logic [3:0] blink_mask;
   logic [7:0] segs;
   logic [3:0] ssd_ctl;

   modport master (
      output dig0, dig1, dig2, dig3, blank_mask, blink_mask,
      input  segs, ssd_ctl
   );

   modport slave (
      input  dig0, dig1, dig2, dig3, blank_mask, blink_mask,
      output segs, ssd_ctl
   );
endinterface

// File: rtl/lab4_ssd_scan_timer.sv
// GUARD/SHOW sequencer: dwell counter, digit index, snapshot and frame strobes.
// The frame strobe port exists only when LAB4_SSD_SCAN_BLINK_EN is defined.
module lab4_ssd_scan_timer
   import lab4_ssd_scan_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int GUARD_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] idx_o,
   output logic       show_stb_o,
   output logic       guard_stb_o,
   output logic       snap_stb_o
`ifdef LAB4_SSD_SCAN_BLINK_EN
   ,
   output logic       frame_stb_o
`endif
);
   localparam int MAX_CYC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
   localparam int CW      = $clog2(MAX_CYC);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;

   assign show_stb_o  = (state_q == GUARD) && (cnt_q == GUARD_LAST);
   assign guard_stb_o = (state_q == SHOW) && (cnt_q == SHOW_LAST);
   assign snap_stb_o  = show_stb_o && (idx_q == 2'd0);
   assign idx_o       = idx_q;
`ifdef LAB4_SSD_SCAN_BLINK_EN
   assign frame_stb_o = guard_stb_o && (idx_q == 2'd3);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      case (state_q)
         GUARD: begin
            if (show_stb_o) begin
               state_d = SHOW;
               cnt_d   = '0;
            end else begin
               state_d = GUARD;
            end
         end
         SHOW: begin
            if (guard_stb_o) begin
               state_d = GUARD;
               cnt_d   = '0;
               idx_d   = idx_q + 2'd1;
            end else begin
               state_d = SHOW;
            end
         end
         default: begin
            state_d = GUARD;
            cnt_d   = '0;
            idx_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GUARD;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: rtl/lab4_ssd_scan.sv
// Four-digit seven-segment scan driver with guard interval and per-frame input snapshot.
// Define LAB4_SSD_SCAN_BLINK_EN to enable per-digit blinking via blink_mask.
module lab4_ssd_scan
   import lab4_ssd_scan_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int GUARD_CYC    = 1000,
   parameter int BLINK_FRAMES = 128
) (
   input  logic           clk,
   input  logic           rst_n,
   lab4_ssd_scan_if.slave ssd
);
   logic [1:0]      idx_s;
   logic            show_stb_s, guard_stb_s, snap_stb_s;
   logic [3:0][7:0] snap_q, snap_d, live_pat_s;
   logic [3:0]      blank_q, blank_d;
   logic [7:0]      segs_q, segs_d;
   logic [3:0]      ctl_q, ctl_d;
   logic            dark_s;

`ifdef LAB4_SSD_SCAN_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic          frame_stb_s;
   logic [3:0]    blink_q, blink_d;
   logic [FW-1:0] fcnt_q;
   logic          phase_q;
`endif

   lab4_ssd_scan_timer #(
      .SCAN_DIV  (SCAN_DIV),
      .GUARD_CYC (GUARD_CYC)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .idx_o       (idx_s),
      .show_stb_o  (show_stb_s),
      .guard_stb_o (guard_stb_s),
      .snap_stb_o  (snap_stb_s)
`ifdef LAB4_SSD_SCAN_BLINK_EN
      ,
      .frame_stb_o (frame_stb_s)
`endif
   );

   assign live_pat_s = {ssd.dig3, ssd.dig2, ssd.dig1, ssd.dig0};

   // Digit 0 reads the snapshot being loaded on this same edge, not the stale one.
   always_comb begin
      snap_d  = snap_stb_s ? live_pat_s : snap_q;
      blank_d = snap_stb_s ? ssd.blank_mask : blank_q;
      dark_s  = blank_d[idx_s];
`ifdef LAB4_SSD_SCAN_BLINK_EN
      blink_d = snap_stb_s ? ssd.blink_mask : blink_q;
      dark_s  = dark_s | (blink_d[idx_s] & phase_q);
`endif
      segs_d = segs_q;
      ctl_d  = ctl_q;
      if (guard_stb_s) begin
         segs_d = SS_BLANK;
         ctl_d  = DIG_OFF;
      end else if (show_stb_s) begin
         segs_d = dark_s ? SS_BLANK : snap_d[idx_s];
         ctl_d  = digit_enable(idx_s);
      end else begin
         segs_d = segs_q;
         ctl_d  = ctl_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q  <= {4{SS_BLANK}};
         blank_q <= 4'b0000;
         segs_q  <= SS_BLANK;
         ctl_q   <= DIG_OFF;
      end else begin
         snap_q  <= snap_d;
         blank_q <= blank_d;
         segs_q  <= segs_d;
         ctl_q   <= ctl_d;
      end
   end

`ifdef LAB4_SSD_SCAN_BLINK_EN
   // Blink phase flips after every BLINK_FRAMES completed frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_q <= 4'b0000;
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         blink_q <= blink_d;
         if (frame_stb_s) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
               fcnt_q  <= '0;
               phase_q <= ~phase_q;
            end else begin
               fcnt_q  <= fcnt_q + FW'(1);
            end
         end
      end
   end
`endif

   assign ssd.segs    = segs_q;
   assign ssd.ssd_ctl = ctl_q;

endmodule

// File: tb/tb_lab4_ssd_scan.sv
// Directed self-checking bench for lab4_ssd_scan (SCAN_DIV=4, GUARD_CYC=2, BLINK_FRAMES=2).
// Blink expectations follow LAB4_SSD_SCAN_BLINK_EN.
module tb_lab4_ssd_scan;
   import lab4_ssd_scan_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [7:0] exp_tab [0:4][0:3];

   lab4_ssd_scan_if ssd_if ();

   lab4_ssd_scan #(
      .SCAN_DIV     (4),
      .GUARD_CYC    (2),
      .BLINK_FRAMES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ssd   (ssd_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      ssd_if.dig0 = SS_0;
      ssd_if.dig1 = SS_3;
      ssd_if.dig2 = SS_F;
      ssd_if.dig3 = SS_F;
      ssd_if.blank_mask = 4'b0000;
      ssd_if.blink_mask = 4'b0001;
      repeat (3) @(negedge clk);
      checks++;
      if (ssd_if.segs !== 8'hFF || ssd_if.ssd_ctl !== 4'b1111) begin
         failures++;
         $display("FAIL reset_hold got=%h/%b exp=ff/1111", ssd_if.segs, ssd_if.ssd_ctl);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (ssd_if.segs !== 8'hFF || ssd_if.ssd_ctl !== 4'b1111) begin
         failures++;
         $display("FAIL reset_release got=%h/%b exp=ff/1111", ssd_if.segs, ssd_if.ssd_ctl);
      end
   endtask

   // Five frames: tearing, blanking and (if built in) blinking on digit 0.
   task automatic test_scan_frames();
      logic [7:0] e_seg;
      logic [3:0] e_ctl;
      int t, f, d;
      exp_tab[0] = '{SS_0, SS_3, SS_F, SS_F};
      exp_tab[1] = '{SS_9, SS_3, SS_F, SS_F};
`ifdef LAB4_SSD_SCAN_BLINK_EN
      exp_tab[2] = '{8'hFF, SS_1, 8'hFF, 8'hFF};
      exp_tab[3] = '{8'hFF, SS_1, 8'hFF, 8'hFF};
`else
      exp_tab[2] = '{SS_9, SS_1, 8'hFF, 8'hFF};
      exp_tab[3] = '{SS_9, SS_1, 8'hFF, 8'hFF};
`endif
      exp_tab[4] = '{SS_9, SS_1, 8'hFF, 8'hFF};
      for (int k = 1; k <= 121; k++) begin
         @(negedge clk);
         e_seg = 8'hFF;
         e_ctl = 4'b1111;
         if (k >= 2) begin
            t = (k - 2) % 24;
            f = (k - 2) / 24;
            d = t / 6;
            if ((t % 6) < 4) begin
               e_ctl = ~(4'b0001 << d);
               e_seg = exp_tab[f][d];
            end
         end
         checks++;
         if (ssd_if.segs !== e_seg || ssd_if.ssd_ctl !== e_ctl) begin
            failures++;
            $display("FAIL scan k=%0d got=%h/%b exp=%h/%b", k, ssd_if.segs, ssd_if.ssd_ctl, e_seg, e_ctl);
         end
         checks++;
         if (!(ssd_if.ssd_ctl inside {4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111}) ||
             (ssd_if.ssd_ctl === 4'b1111 && ssd_if.segs !== 8'hFF)) begin
            failures++;
            $display("FAIL legal k=%0d got=%h/%b exp=one-cold or ff/1111", k, ssd_if.segs, ssd_if.ssd_ctl);
         end
         if (k == 14) ssd_if.dig0 = SS_9;
         if (k == 27) begin
            ssd_if.dig1 = SS_1;
            ssd_if.blank_mask = 4'b1100;
         end
      end
   endtask

   task automatic test_reset_mid_show();
      logic [7:0] e_seg;
      logic [3:0] e_ctl;
      int t, d;
      repeat (8) @(negedge clk);
      checks++;
      if (ssd_if.segs !== SS_1 || ssd_if.ssd_ctl !== 4'b1101) begin
         failures++;
         $display("FAIL pre_reset_digit1 got=%h/%b exp=%h/1101", ssd_if.segs, ssd_if.ssd_ctl, SS_1);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ssd_if.segs !== 8'hFF || ssd_if.ssd_ctl !== 4'b1111) begin
         failures++;
         $display("FAIL async_reset got=%h/%b exp=ff/1111", ssd_if.segs, ssd_if.ssd_ctl);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         e_seg = 8'hFF;
         e_ctl = 4'b1111;
         if (k >= 2) begin
            t = k - 2;
            d = t / 6;
            if ((t % 6) < 4) begin
               e_ctl = ~(4'b0001 << d);
               e_seg = (d == 0) ? SS_9 : SS_1;
            end
         end
         checks++;
         if (ssd_if.segs !== e_seg || ssd_if.ssd_ctl !== e_ctl) begin
            failures++;
            $display("FAIL restart k=%0d got=%h/%b exp=%h/%b", k, ssd_if.segs, ssd_if.ssd_ctl, e_seg, e_ctl);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_scan_frames();
      test_reset_mid_show();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
